exc_ctrl: RTL and testbench



---
 rtl/exc_ctrl.sv | 133 +++++++++++++
 tb/tb_exc_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt resolver and pipeline flush/stall sequencer for the MIPS32 MEM stage.
// Define EXC_CTRL_STATS_EN to build the taken-exception counter behind exc_count_o.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        mem_inst_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic        mem_syscall_i,
    input  logic        mem_invalid_i,
    input  logic        mem_trap_i,
    input  logic        mem_ov_i,
    input  logic        mem_eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o,
    output logic [15:0] exc_count_o
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic        int_pending;
    logic        taken;
    logic        in_hold;
    logic [31:0] code;
    logic [31:0] redirect_pc;

    logic unused_cp0;
    assign unused_cp0 = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                          cp0_cause_i[31:16], cp0_cause_i[7:0]};

    assign current_inst_addr_o = mem_pc_i;
    assign is_in_delayslot_o   = mem_in_delayslot_i;

    always_comb begin
        int_pending = cp0_status_i[0] & ~cp0_status_i[1] &
                      (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));
        code = 32'h0;
        // Gating on rst forces the combinational outputs to their reset values.
        if (rst && (state_q == StIdle) && mem_inst_valid_i) begin
            if (int_pending)        code = 32'h1;
            else if (mem_syscall_i) code = 32'h8;
            else if (mem_invalid_i) code = 32'ha;
            else if (mem_trap_i)    code = 32'hd;
            else if (mem_ov_i)      code = 32'hc;
            else if (mem_eret_i)    code = 32'he;
        end
        taken       = (code != 32'h0);
        in_hold     = rst && (state_q == StHold);
        redirect_pc = (code == 32'he) ? cp0_epc_i : EXC_VECTOR;
    end

    always_comb begin
        excepttype_o = code;
        flush_o      = taken | in_hold;
        new_pc_o     = 32'h0;
        if (taken)        new_pc_o = redirect_pc;
        else if (in_hold) new_pc_o = hold_pc_q;
        stall_o = 6'b000000;
        if (rst && !flush_o) begin
            if (stallreq_ex_i)      stall_o = 6'b001111;
            else if (stallreq_id_i) stall_o = 6'b000111;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        hold_pc_d  = hold_pc_q;
        unique case (state_q)
            StIdle: begin
                if (taken && (FLUSH_CYCLES > 1)) begin
                    state_d    = StHold;
                    hold_cnt_d = 4'(FLUSH_CYCLES - 1);
                    hold_pc_d  = redirect_pc;
                end
            end
            StHold: begin
                if (hold_cnt_q <= 4'd1) begin
                    state_d    = StIdle;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            hold_cnt_q <= 4'd0;
            hold_pc_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            hold_pc_q  <= hold_pc_d;
        end
    end

`ifdef EXC_CTRL_STATS_EN
    logic [15:0] exc_count_q, exc_count_d;

    // Eret is a return, not an exception, so it is not counted.
    assign exc_count_d = (taken && (code != 32'he)) ? exc_count_q + 16'd1 : exc_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exc_count_q <= 16'h0000;
        else      exc_count_q <= exc_count_d;
    end

    assign exc_count_o = exc_count_q;
`else
    assign exc_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: two instances (1- and 3-cycle flush) against a
// priority/flush-window reference model, directed cases followed by random traffic.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id_i, stallreq_ex_i, mem_inst_valid_i, mem_in_delayslot_i;
    logic [31:0] mem_pc_i;
    logic        mem_syscall_i, mem_invalid_i, mem_trap_i, mem_ov_i, mem_eret_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;

    logic [31:0] a_code, a_addr, a_pc, b_code, b_addr, b_pc;
    logic        a_ds, a_flush, b_ds, b_flush;
    logic [5:0]  a_stall, b_stall;
    logic [15:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int          left [2];
    logic [31:0] held [2];
    logic [15:0] cnt  [2];
    int          kcyc [2] = '{1, 3};

    always #5 clk = ~clk;

    exc_ctrl u_dut_a (
        .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .mem_inst_valid_i(mem_inst_valid_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_syscall_i(mem_syscall_i),
        .mem_invalid_i(mem_invalid_i), .mem_trap_i(mem_trap_i), .mem_ov_i(mem_ov_i),
        .mem_eret_i(mem_eret_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
        .cp0_epc_i(cp0_epc_i), .excepttype_o(a_code), .current_inst_addr_o(a_addr),
        .is_in_delayslot_o(a_ds), .flush_o(a_flush), .new_pc_o(a_pc), .stall_o(a_stall),
        .exc_count_o(a_cnt)
    );

    exc_ctrl #(.FLUSH_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .mem_inst_valid_i(mem_inst_valid_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_syscall_i(mem_syscall_i),
        .mem_invalid_i(mem_invalid_i), .mem_trap_i(mem_trap_i), .mem_ov_i(mem_ov_i),
        .mem_eret_i(mem_eret_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
        .cp0_epc_i(cp0_epc_i), .excepttype_o(b_code), .current_inst_addr_o(b_addr),
        .is_in_delayslot_o(b_ds), .flush_o(b_flush), .new_pc_o(b_pc), .stall_o(b_stall),
        .exc_count_o(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_code();
        logic irq;
        irq = cp0_status_i[0] && !cp0_status_i[1] &&
              ((cp0_cause_i[15:8] & cp0_status_i[15:8]) != 8'h00);
        if (!mem_inst_valid_i) return 32'h0;
        if (irq)               return 32'h1;
        if (mem_syscall_i)     return 32'h8;
        if (mem_invalid_i)     return 32'ha;
        if (mem_trap_i)        return 32'hd;
        if (mem_ov_i)          return 32'hc;
        if (mem_eret_i)        return 32'he;
        return 32'h0;
    endfunction

    function automatic logic [15:0] exp_count(input int i);
`ifdef EXC_CTRL_STATS_EN
        return cnt[i];
`else
        return 16'h0000 & cnt[i];
`endif
    endfunction

    // Compare both instances with the model, then advance the model past the next edge.
    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e_code, e_pc;
            logic        e_flush;
            logic [5:0]  e_stall;
            string       p;
            p = $sformatf("k%0d", kcyc[i]);
            if (left[i] > 0) begin
                e_code = 32'h0; e_flush = 1'b1; e_pc = held[i]; e_stall = 6'd0;
            end else begin
                e_code = ref_code();
                if (e_code != 32'h0) begin
                    e_flush = 1'b1; e_stall = 6'd0;
                    e_pc = (e_code == 32'he) ? cp0_epc_i : 32'h0000_0020;
                end else begin
                    e_flush = 1'b0; e_pc = 32'h0;
                    e_stall = stallreq_ex_i ? 6'b001111 : (stallreq_id_i ? 6'b000111 : 6'd0);
                end
            end
            check_eq({p, " excepttype"}, (i == 0) ? a_code : b_code, e_code);
            check_eq({p, " flush"}, {31'd0, (i == 0) ? a_flush : b_flush}, {31'd0, e_flush});
            check_eq({p, " new_pc"}, (i == 0) ? a_pc : b_pc, e_pc);
            check_eq({p, " stall"}, {26'd0, (i == 0) ? a_stall : b_stall}, {26'd0, e_stall});
            check_eq({p, " exc_count"}, {16'd0, (i == 0) ? a_cnt : b_cnt}, {16'd0, exp_count(i)});
            check_eq({p, " inst_addr"}, (i == 0) ? a_addr : b_addr, mem_pc_i);
            check_eq({p, " delayslot"}, {31'd0, (i == 0) ? a_ds : b_ds},
                     {31'd0, mem_in_delayslot_i});
            if (left[i] > 0) begin
                left[i]--;
            end else if (e_code != 32'h0) begin
                if (kcyc[i] > 1) begin
                    left[i] = kcyc[i] - 1;
                    held[i] = e_pc;
                end
                if (e_code != 32'he) cnt[i] = cnt[i] + 16'd1;
            end
        end
    endtask

    task automatic clear_inputs();
        stallreq_id_i = 0; stallreq_ex_i = 0; mem_inst_valid_i = 0; mem_in_delayslot_i = 0;
        mem_pc_i = 32'h0; mem_syscall_i = 0; mem_invalid_i = 0; mem_trap_i = 0; mem_ov_i = 0;
        mem_eret_i = 0; cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    endtask

    task automatic cycle_start();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic cycle_end();
        #1;
        check_all();
    endtask

    // Asserts reset at a negedge with whatever inputs are applied; outputs must read zero.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check_eq("rst k1 flush", {31'd0, a_flush}, 32'd0);
            check_eq("rst k3 flush", {31'd0, b_flush}, 32'd0);
            check_eq("rst k1 code", a_code, 32'h0);
            check_eq("rst k3 code", b_code, 32'h0);
            check_eq("rst k3 new_pc", b_pc, 32'h0);
            check_eq("rst k1 stall", {26'd0, a_stall}, 32'd0);
            check_eq("rst k3 count", {16'd0, b_cnt}, 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; held[i] = 32'h0; cnt[i] = 16'h0;
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            cycle_start();
            cycle_end();
        end
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; held[i] = 32'h0; cnt[i] = 16'h0;
        end
        mem_inst_valid_i = 1; mem_syscall_i = 1; stallreq_ex_i = 1;
        do_reset(2);

        // Syscall at 0x100, then flush drops (k=1) or holds (k=3).
        cycle_start(); mem_inst_valid_i = 1; mem_pc_i = 32'h100; mem_syscall_i = 1; cycle_end();
        idle(3);
        // Interrupt beats syscall; with EXL set the syscall is taken instead.
        cycle_start(); mem_inst_valid_i = 1; cp0_status_i = 32'h0000_0401;
        cp0_cause_i = 32'h0000_0400; mem_syscall_i = 1; cycle_end();
        idle(3);
        cycle_start(); mem_inst_valid_i = 1; cp0_status_i = 32'h0000_0403;
        cp0_cause_i = 32'h0000_0400; mem_syscall_i = 1; cycle_end();
        idle(3);
        // Eret redirects to EPC; eret with a pending interrupt takes the interrupt.
        cycle_start(); mem_inst_valid_i = 1; mem_eret_i = 1; cp0_epc_i = 32'h440; cycle_end();
        idle(3);
        cycle_start(); mem_inst_valid_i = 1; mem_eret_i = 1; cp0_epc_i = 32'h440;
        cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400; cycle_end();
        idle(3);
        // Stall encoding, and an overflow during an EX stall.
        cycle_start(); stallreq_ex_i = 1; stallreq_id_i = 1; cycle_end();
        cycle_start(); stallreq_id_i = 1; cycle_end();
        cycle_start(); stallreq_ex_i = 1; mem_inst_valid_i = 1; mem_ov_i = 1; cycle_end();
        cycle_start(); stallreq_ex_i = 1; cycle_end();
        cycle_start(); stallreq_ex_i = 1; cycle_end();
        cycle_start(); stallreq_ex_i = 1; cycle_end();
        // Flags without a valid instruction are ignored.
        cycle_start(); mem_syscall_i = 1; mem_trap_i = 1; mem_eret_i = 1; cycle_end();
        // Invalid, trap during hold ignored, then reset aborts the hold.
        cycle_start(); mem_inst_valid_i = 1; mem_invalid_i = 1; mem_pc_i = 32'h200;
        mem_in_delayslot_i = 1; cycle_end();
        cycle_start(); mem_inst_valid_i = 1; mem_trap_i = 1; cycle_end();
        mem_inst_valid_i = 1; mem_trap_i = 1;
        do_reset(1);
        idle(2);
        // Three syscalls and one eret, spaced past the hold window.
        for (int r = 0; r < 4; r++) begin
            cycle_start(); mem_inst_valid_i = 1;
            if (r == 2) mem_eret_i = 1; else mem_syscall_i = 1;
            cycle_end();
            idle(3);
        end

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(299) == 0) begin
                do_reset(1 + $urandom_range(1));
            end
            cycle_start();
            mem_inst_valid_i   = ($urandom_range(3) != 0);
            mem_pc_i           = $urandom();
            mem_in_delayslot_i = $urandom_range(1) == 1;
            mem_syscall_i      = ($urandom_range(5) == 0);
            mem_invalid_i      = ($urandom_range(5) == 0);
            mem_trap_i         = ($urandom_range(5) == 0);
            mem_ov_i           = ($urandom_range(5) == 0);
            mem_eret_i         = ($urandom_range(5) == 0);
            stallreq_id_i      = ($urandom_range(2) == 0);
            stallreq_ex_i      = ($urandom_range(3) == 0);
            cp0_status_i       = $urandom();
            cp0_status_i[1]    = ($urandom_range(3) == 0);
            cp0_cause_i        = $urandom();
            if ($urandom_range(1) == 1) cp0_cause_i[15:8] = 8'h00;
            cp0_epc_i          = $urandom();
            cycle_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
